// File: rtl/input_pkg.sv
// Shared constants and types for the player input conditioning path.
package input_pkg;

  localparam int unsigned N_BTN     = 6;
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_CHOP  = 4;
  localparam int unsigned BTN_CARRY = 5;

  typedef logic [N_BTN-1:0] btn_vec_t;

  // Values presented to the game controller for one whole frame.
  typedef struct packed {
    btn_vec_t level;
    logic     pause;
  } frame_out_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a stable-time debouncer.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 650_000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             sync_c;

  assign sync_c = sync_q[1];

  // Any return to the stable value restarts the count from zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_c == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_c;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw buttons and pause switch, latching them once per frame on vsync fall.
module input_conditioner
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             vsync_in,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             pause_sw_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             pause,
  output logic [N_BTN-1:0] btn_press,
  output logic             frame_tick
);

  localparam int unsigned N_DB = N_BTN + 1;

  logic [N_DB-1:0] raw_all;
  logic [N_DB-1:0] stable_all;
  btn_vec_t        stable_btn;
  btn_vec_t        stable_d;
  btn_vec_t        sticky;
  logic            stable_pause;
  logic [1:0]      vsync_sync;
  logic            vsync_prev;
  logic            vfall_c;
  frame_out_t      frame_q;

  assign raw_all      = {pause_sw_in, btn_in};
  assign stable_btn   = stable_all[N_BTN-1:0];
  assign stable_pause = stable_all[N_BTN];

  for (genvar i = 0; i < int'(N_DB); i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .raw   (raw_all[i]),
      .stable(stable_all[i])
    );
  end

  assign vfall_c = vsync_prev & ~vsync_sync[1];

  // Vsync synchroniser and falling-edge register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vsync_sync <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_sync <= {vsync_sync[0], vsync_in};
      vsync_prev <= vsync_sync[1];
    end
  end

  // Press pulses, sticky capture and the per-frame latch; a press in the update cycle goes straight into the latch.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stable_d   <= '0;
      btn_press  <= '0;
      sticky     <= '0;
      frame_q    <= '0;
      frame_tick <= 1'b0;
    end else begin
      stable_d   <= stable_btn;
      btn_press  <= stable_btn & ~stable_d;
      frame_tick <= vfall_c;
      if (vfall_c) begin
        sticky        <= '0;
        frame_q.level <= stable_btn | sticky | btn_press;
        frame_q.pause <= stable_pause;
      end else begin
        sticky <= sticky | btn_press;
      end
    end
  end

  assign btn_level = frame_q.level;
  assign pause     = frame_q.pause;

endmodule
